aes_key_expand: RTL

Iterative AES-128 key-schedule engine that takes one 128-bit cipher key and streams the 11 round keys, one per accepted beat, over a valid/ready interface. It sits beside the round datapath: the `add_round_key` stage after `mix_columns` consumes its output, beat by beat. Key bytes use the same `[3:0][3:0][7:0]` column/row packing as the round datapath:

- FIPS column c maps to index 3-c.
- FIPS row r maps to index 3-r.
- The first key byte is therefore `[3][3]`, the MSB of the 128-bit hex literal.

---
 rtl/aes_key_expand.sv | 132 +++++++++++++
 1 files changed

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule that streams round keys 0..NUM_ROUNDS, one per rk handshake.
// Latency: round 0 is valid the cycle after the key handshake, then one round per accepted beat.
// Backpressure: rk_data/rk_round/rk_last hold while rk_valid && !rk_ready; key_ready is low while busy.
module aes_key_expand #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  key_valid,
  output logic                  key_ready,
  input  logic [3:0][3:0][7:0]  key_in,
  output logic                  rk_valid,
  input  logic                  rk_ready,
  output logic [3:0][3:0][7:0]  rk_data,
  output logic [3:0]            rk_round,
  output logic                  rk_last
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t state, state_nxt;
  logic [7:0] rcon;
  logic       is_last;
  logic       accept;
  logic       advance;

  logic [3:0][7:0]       rot_word;
  logic [3:0][7:0]       sub_word;
  logic [3:0][3:0][7:0]  nxt_key;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254, so 0 maps to 0) followed by the FIPS affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign is_last = (rk_round == LAST_ROUND);
  assign accept  = key_valid && key_ready;
  assign advance = rk_valid && rk_ready && !flush;

  // FIPS word wN lives at column index 3-N; byte 0 of a word sits at index 3.
  always_comb begin
    rot_word = {rk_data[0][2], rk_data[0][1], rk_data[0][0], rk_data[0][3]};
    sub_word = '0;
    for (int b = 0; b < 4; b++) begin
      sub_word[b] = sbox(rot_word[b]);
    end
    sub_word[3] = sub_word[3] ^ rcon;
    nxt_key     = '0;
    nxt_key[3]  = rk_data[3] ^ sub_word;
    nxt_key[2]  = rk_data[2] ^ nxt_key[3];
    nxt_key[1]  = rk_data[1] ^ nxt_key[2];
    nxt_key[0]  = rk_data[0] ^ nxt_key[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    key_ready = 1'b0;
    rk_valid  = 1'b0;
    case (state)
      IDLE: begin
        key_ready = !flush;
        if (key_valid && !flush) state_nxt = EMIT;
      end
      EMIT: begin
        rk_valid = 1'b1;
        if (rk_ready && is_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Flush only drops rk_last; rk_data/rk_round are left as they were.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_data  <= '0;
      rk_round <= '0;
      rk_last  <= 1'b0;
      rcon     <= 8'h01;
    end else if (flush) begin
      rk_last  <= 1'b0;
    end else if (accept) begin
      rk_data  <= key_in;
      rk_round <= '0;
      rcon     <= 8'h01;
      rk_last  <= (LAST_ROUND == 4'd0);
    end else if (advance) begin
      if (is_last) begin
        rk_last  <= 1'b0;
      end else begin
        rk_data  <= nxt_key;
        rk_round <= rk_round + 4'd1;
        rcon     <= xtime(rcon);
        rk_last  <= ((rk_round + 4'd1) == LAST_ROUND);
      end
    end
  end

endmodule
